// File: rtl/v35_intc.sv
// V35-style vectored interrupt controller: per-channel xIC/MODE registers,
// priority arbitration against the in-service register, req/ack/fini handshake.
module v35_intc #(
   parameter int NUM_CH   = 8,
   parameter int VEC_BASE = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   input  logic [NUM_CH-1:0] irq_in,
   input  logic              reg_wr,
   input  logic              reg_rd,
   input  logic [5:0]        reg_addr,
   input  logic [7:0]        reg_din,
   output logic [7:0]        reg_dout,
   output logic              irq_req,
   output logic [7:0]        irq_vec,
   input  logic              irq_ack,
   input  logic              irq_fini
);
   localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

   state_t            state_reg, state_next;
   logic [7:0]        ic_reg   [NUM_CH];
   logic [1:0]        mode_reg [NUM_CH];
   logic [NUM_CH-1:0] prev_reg;
   logic [NUM_CH-1:0] hw_set;
   logic [NUM_CH-1:0] eligible;
   logic [7:0]        ispr_reg, ispr_next;
   logic [CW-1:0]     ch_reg, ch_next;
   logic [2:0]        pr_reg, pr_next;
   logic              req_next;
   logic [7:0]        vec_next;
   logic              ack_fire;
   logic              sel_valid;
   logic [CW-1:0]     sel_ch;
   logic [2:0]        sel_pr;
   logic [4:0]        addr_idx;
   logic [CW-1:0]     rd_idx;
   logic              addr_in_range;

   assign addr_idx      = reg_addr[4:0];
   assign rd_idx        = addr_idx[CW-1:0];
   assign addr_in_range = (int'(addr_idx) < NUM_CH);

   // Blocking mask covers the channel's own level and every higher one.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic       active;
      logic [7:0] blk_mask;
      assign active       = (irq_in[gi] == mode_reg[gi][0]);
      assign hw_set[gi]   = ce & active & (mode_reg[gi][1] | (irq_in[gi] != prev_reg[gi]));
      assign blk_mask     = 8'((9'd2 << ic_reg[gi][2:0]) - 9'd1);
      assign eligible[gi] = ic_reg[gi][7] & ~ic_reg[gi][6] & ((ispr_reg & blk_mask) == 8'd0);
   end

   // Ack clears IF, a register write overrides that, a hardware set overrides both.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_reg <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            ic_reg[i]   <= 8'h47;
            mode_reg[i] <= 2'b00;
         end
      end else begin
         if (ce)
            prev_reg <= irq_in;
         for (int i = 0; i < NUM_CH; i++) begin
            if (ack_fire && int'(ch_reg) == i)
               ic_reg[i][7] <= 1'b0;
            if (reg_wr && int'(reg_addr) == i)
               ic_reg[i] <= reg_din;
            if (hw_set[i])
               ic_reg[i][7] <= 1'b1;
            if (reg_wr && int'(reg_addr) == 32 + i)
               mode_reg[i] <= reg_din[1:0];
         end
      end
   end

   // Lowest PR wins; strict compare keeps the lowest index on a tie.
   always_comb begin
      sel_valid = 1'b0;
      sel_ch    = '0;
      sel_pr    = 3'd7;
      for (int i = 0; i < NUM_CH; i++) begin
         if (eligible[i] && (!sel_valid || ic_reg[i][2:0] < sel_pr)) begin
            sel_valid = 1'b1;
            sel_ch    = CW'(i);
            sel_pr    = ic_reg[i][2:0];
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ch_next    = ch_reg;
      pr_next    = pr_reg;
      req_next   = irq_req;
      vec_next   = irq_vec;
      ack_fire   = 1'b0;
      if (ce) begin
         case (state_reg)
            IDLE: begin
               if (sel_valid) begin
                  state_next = PEND;
                  ch_next    = sel_ch;
                  pr_next    = sel_pr;
                  req_next   = 1'b1;
                  vec_next   = 8'(VEC_BASE + int'(sel_ch));
               end
            end
            PEND: begin
               if (irq_ack) begin
                  ack_fire   = 1'b1;
                  req_next   = 1'b0;
                  state_next = IDLE;
               end else if (!ic_reg[ch_reg][7] || ic_reg[ch_reg][6]) begin
                  req_next   = 1'b0;
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Fini retires against the old ISPR before the acked level is added.
   always_comb begin
      ispr_next = ispr_reg;
      if (ce && irq_fini)
         ispr_next = ispr_reg & (ispr_reg - 8'd1);
      if (ack_fire)
         ispr_next = ispr_next | (8'd1 << pr_reg);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         ch_reg    <= '0;
         pr_reg    <= '0;
         irq_req   <= 1'b0;
         irq_vec   <= 8'(VEC_BASE);
         ispr_reg  <= 8'd0;
      end else begin
         state_reg <= state_next;
         ch_reg    <= ch_next;
         pr_reg    <= pr_next;
         irq_req   <= req_next;
         irq_vec   <= vec_next;
         ispr_reg  <= ispr_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         reg_dout <= 8'd0;
      else if (reg_rd) begin
         if (!reg_addr[5] && addr_in_range)
            reg_dout <= ic_reg[rd_idx];
         else if (reg_addr[5] && addr_in_range)
            reg_dout <= {6'd0, mode_reg[rd_idx]};
         else if (reg_addr == 6'h3C)
            reg_dout <= ispr_reg;
         else
            reg_dout <= 8'd0;
      end
   end
endmodule

// File: tb/tb_v35_intc.sv
// Directed bench for v35_intc: expected reads and requests are queued by the
// stimulus and retired by a monitor as the DUT presents them.
`timescale 1ns/1ps
module tb_v35_intc;
   localparam int NUM_CH   = 8;
   localparam int VEC_BASE = 24;

   logic              clk      = 1'b0;
   logic              reset    = 1'b1;
   logic              ce       = 1'b1;
   logic [NUM_CH-1:0] irq_in   = '0;
   logic              reg_wr   = 1'b0;
   logic              reg_rd   = 1'b0;
   logic [5:0]        reg_addr = '0;
   logic [7:0]        reg_din  = '0;
   logic              irq_ack  = 1'b0;
   logic              irq_fini = 1'b0;
   logic [7:0]        reg_dout;
   logic              irq_req;
   logic [7:0]        irq_vec;

   typedef struct {string name; logic [7:0] data;} rd_exp_t;
   typedef struct {string name; logic [7:0] vec; int at;} req_exp_t;

   rd_exp_t  rd_q[$];
   req_exp_t req_q[$];
   rd_exp_t  re;
   req_exp_t qe;
   int       cyc    = 0;
   int       n_chk  = 0;
   int       n_pass = 0;
   logic     req_prev = 1'b0;
   logic     rd_fire;

   always #5 clk = ~clk;

   v35_intc #(.NUM_CH(NUM_CH), .VEC_BASE(VEC_BASE)) dut (
      .clk(clk), .reset(reset), .ce(ce), .irq_in(irq_in),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_din(reg_din),
      .reg_dout(reg_dout), .irq_req(irq_req), .irq_vec(irq_vec),
      .irq_ack(irq_ack), .irq_fini(irq_fini)
   );

   function automatic void check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) begin
         n_pass++;
         $display("ok   %-16s act=0x%0h cyc=%0d", name, act, cyc);
      end else
         $display("FAIL %s act=0x%0h exp=0x%0h cyc=%0d", name, act, exp, cyc);
   endfunction

   function automatic void flag(input string name, input string what);
      n_chk++;
      $display("FAIL %s %s cyc=%0d", name, what, cyc);
   endfunction

   // Monitor: retires a read one edge after reg_rd, a request on each irq_req rise.
   always @(posedge clk) begin
      cyc++;
      rd_fire = reg_rd;
      #1;
      if (rd_fire) begin
         if (rd_q.size() == 0)
            flag("rd_unexpected", $sformatf("act=0x%0h required=none", reg_dout));
         else begin
            re = rd_q.pop_front();
            check(re.name, reg_dout, re.data);
         end
      end
      if (irq_req && !req_prev) begin
         if (req_q.size() == 0)
            flag("req_unexpected", $sformatf("vec act=%0d required=none", irq_vec));
         else begin
            qe = req_q.pop_front();
            check({qe.name, "_vec"}, irq_vec, qe.vec);
            check({qe.name, "_cyc"}, cyc, qe.at);
         end
      end
      req_prev = irq_req;
   end

   // All tasks start just after a falling edge and return at a later one.
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [5:0] a, input logic [7:0] d);
      reg_wr = 1'b1; reg_addr = a; reg_din = d;
      @(negedge clk);
      reg_wr = 1'b0;
   endtask

   task automatic rd(input string name, input logic [5:0] a, input logic [7:0] e);
      rd_q.push_back('{name: name, data: e});
      reg_rd = 1'b1; reg_addr = a;
      @(negedge clk);
      reg_rd = 1'b0;
   endtask

   task automatic wrrd(input string name, input logic [5:0] a, input logic [7:0] d,
                       input logic [7:0] e);
      rd_q.push_back('{name: name, data: e});
      reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = a; reg_din = d;
      @(negedge clk);
      reg_wr = 1'b0; reg_rd = 1'b0;
   endtask

   task automatic set_in(input logic [NUM_CH-1:0] v);
      irq_in = v;
      @(negedge clk);
   endtask

   task automatic exp_req(input string name, input logic [7:0] vec, input int dly);
      req_q.push_back('{name: name, vec: vec, at: cyc + dly});
   endtask

   task automatic wait_req(input string name);
      int n = 0;
      while (!irq_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!irq_req)
         flag(name, "timeout act=irq_req 0 required=1");
   endtask

   task automatic ack(input string name);
      wait_req(name);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
   endtask

   task automatic ackfini(input string name);
      wait_req(name);
      irq_ack = 1'b1; irq_fini = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0; irq_fini = 1'b0;
   endtask

   task automatic fini();
      irq_fini = 1'b1;
      @(negedge clk);
      irq_fini = 1'b0;
   endtask

   task automatic do_reset();
      irq_in = '0; ce = 1'b1; reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      reset = 1'b0;
      // Reset state and register map
      check("rst_req", irq_req, 0);
      check("rst_vec", irq_vec, VEC_BASE);
      check("rst_dout", reg_dout, 0);
      rd("rst_ic0", 6'h00, 8'h47);
      rd("rst_ic7", 6'h07, 8'h47);
      rd("rst_mode3", 6'h23, 8'h00);
      rd("rst_ispr", 6'h3C, 8'h00);
      rd("unmapped_10", 6'h10, 8'h00);
      rd("unmapped_28", 6'h28, 8'h00);
      wr(6'h23, 8'hFF);
      rd("mode3_bits", 6'h23, 8'h03);
      wr(6'h3C, 8'hFF);
      rd("ispr_ro", 6'h3C, 8'h00);
      wrrd("rd_old_ic5", 6'h05, 8'hC5, 8'h47);
      rd("rd_new_ic5", 6'h05, 8'hC5);

      // Single rising edge, two-ce latency
      do_reset();
      wr(6'h02, 8'h03);
      wr(6'h22, 8'h01);
      exp_req("t1_ch2", 8'd26, 2);
      set_in(8'h04);
      ack("t1_ch2");
      rd("t1_ispr", 6'h3C, 8'h08);
      rd("t1_ic2", 6'h02, 8'h03);

      // Priority selection and blocking until fini
      do_reset();
      wr(6'h01, 8'h05); wr(6'h04, 8'h02);
      wr(6'h21, 8'h01); wr(6'h24, 8'h01);
      exp_req("t2_ch4", 8'd28, 2);
      set_in(8'h12);
      ack("t2_ch4");
      rd("t2_ispr_a", 6'h3C, 8'h04);
      rd("t2_ic4", 6'h04, 8'h02);
      rd("t2_ic1", 6'h01, 8'h85);
      exp_req("t2_ch1", 8'd25, 2);
      fini();
      rd("t2_ispr_b", 6'h3C, 8'h00);
      ack("t2_ch1");
      rd("t2_ispr_c", 6'h3C, 8'h20);

      // Equal priority tie, with ce held low across the input change
      do_reset();
      wr(6'h00, 8'h03); wr(6'h05, 8'h03);
      wr(6'h20, 8'h01); wr(6'h25, 8'h01);
      ce = 1'b0;
      set_in(8'h21);
      tick(2);
      ce = 1'b1;
      exp_req("t3_ch0", 8'd24, 2);
      ack("t3_ch0");
      rd("t3_ispr", 6'h3C, 8'h08);
      exp_req("t3_ch5", 8'd29, 2);
      fini();
      ack("t3_ch5");
      fini();

      // Nesting
      do_reset();
      wr(6'h03, 8'h04); wr(6'h06, 8'h01); wr(6'h07, 8'h04);
      wr(6'h23, 8'h01); wr(6'h26, 8'h01); wr(6'h27, 8'h01);
      exp_req("t4_ch3", 8'd27, 2);
      set_in(8'h08);
      ack("t4_ch3");
      rd("t4_ispr_a", 6'h3C, 8'h10);
      exp_req("t4_ch6", 8'd30, 2);
      set_in(8'h48);
      ack("t4_ch6");
      rd("t4_ispr_b", 6'h3C, 8'h12);
      set_in(8'hC8);
      rd("t4_ic7", 6'h07, 8'h84);
      fini();
      rd("t4_ispr_c", 6'h3C, 8'h10);
      exp_req("t4_ch7", 8'd31, 2);
      fini();
      rd("t4_ispr_d", 6'h3C, 8'h00);
      ack("t4_ch7");
      fini();

      // Level mode, active-low
      do_reset();
      wr(6'h00, 8'h02);
      exp_req("t5_lvl_a", 8'd24, 3);
      wr(6'h20, 8'h02);
      ack("t5_lvl_a");
      rd("t5_ic0_a", 6'h00, 8'h82);
      rd("t5_ispr_a", 6'h3C, 8'h04);
      exp_req("t5_lvl_b", 8'd24, 2);
      fini();
      wait_req("t5_lvl_b");
      set_in(8'h01);
      ack("t5_lvl_b");
      rd("t5_ic0_b", 6'h00, 8'h02);
      fini();
      tick(6);
      rd("t5_ispr_b", 6'h3C, 8'h00);

      // Software withdraw, then simultaneous ack and fini
      do_reset();
      wr(6'h01, 8'h02); wr(6'h21, 8'h01);
      exp_req("t6_ch1", 8'd25, 2);
      set_in(8'h02);
      wait_req("t6_ch1");
      wr(6'h01, 8'hC2);
      check("t6_req_held", irq_req, 1);
      tick(1);
      check("t6_req_drop", irq_req, 0);
      rd("t6_ispr_a", 6'h3C, 8'h00);
      wr(6'h03, 8'h03); wr(6'h23, 8'h01);
      exp_req("t6_ch3", 8'd27, 2);
      set_in(8'h0A);
      ack("t6_ch3");
      rd("t6_ispr_b", 6'h3C, 8'h08);
      wr(6'h02, 8'h02); wr(6'h22, 8'h01);
      exp_req("t6_ch2", 8'd26, 2);
      set_in(8'h0E);
      ackfini("t6_ch2");
      rd("t6_ispr_c", 6'h3C, 8'h04);

      // Software-set IF, then reset while pending
      do_reset();
      exp_req("t7_sw", 8'd27, 2);
      wr(6'h03, 8'h81);
      wait_req("t7_sw");
      reset = 1'b1; ce = 1'b0;
      @(negedge clk);
      check("t7_rst_req", irq_req, 0);
      check("t7_rst_vec", irq_vec, VEC_BASE);
      reset = 1'b0; ce = 1'b1;
      rd("t7_ic3", 6'h03, 8'h47);

      tick(4);
      check("rd_q_left", rd_q.size(), 0);
      check("req_q_left", req_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
